// File: rtl/bf_lut_eval_if.sv
// rtl/bf_lut_eval_if.sv - evaluate, config and sweep signal bundle for bf_lut_eval
//
// Purpose: groups every non-clock/reset signal of bf_lut_eval.
// Ports (slave = the LUT unit, master = its driver):
//   in_vec/in_valid             evaluation request
//   out_x/out_valid             registered evaluation result
//   cfg_we/cfg_addr/cfg_data    truth-table bit write
//   cfg_err                     write rejected because a sweep is running
//   sweep_start/busy/sweep_done minterm sweep control and status
//   ones_count                  true-minterm count from the last sweep
interface bf_lut_eval_if #(
  parameter int N_IN = 3
);
  logic [N_IN-1:0] in_vec;
  logic            in_valid;
  logic            out_x;
  logic            out_valid;
  logic            cfg_we;
  logic [N_IN-1:0] cfg_addr;
  logic            cfg_data;
  logic            cfg_err;
  logic            sweep_start;
  logic            busy;
  logic            sweep_done;
  logic [N_IN:0]   ones_count;

  modport slave (
    input  in_vec, in_valid, cfg_we, cfg_addr, cfg_data, sweep_start,
    output out_x, out_valid, cfg_err, busy, sweep_done, ones_count
  );

  modport master (
    output in_vec, in_valid, cfg_we, cfg_addr, cfg_data, sweep_start,
    input  out_x, out_valid, cfg_err, busy, sweep_done, ones_count
  );
endinterface

// File: rtl/bf_lut_eval.sv
// rtl/bf_lut_eval.sv - programmable N-input boolean function with minterm sweep
//
// Purpose: a 2^N_IN-bit truth table, writable at run time, evaluates input
// vectors with a one-cycle registered result. A sweep walks every minterm
// and reports how many evaluate true.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    bf_lut_eval_if.slave (evaluate, config and sweep signals)
module bf_lut_eval #(
  parameter int                       N_IN      = 3,
  parameter logic [(1<<N_IN)-1:0]     DEF_TABLE = 8'h57
) (
  input  logic          clk,
  input  logic          rst_n,
  bf_lut_eval_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [(1<<N_IN)-1:0] tbl;
  logic [1:0]           state;
  logic [N_IN-1:0]      idx;
  logic [N_IN:0]        acc;
  logic                 out_x_q;
  logic                 out_valid_q;
  logic                 cfg_err_q;
  logic                 busy_q;
  logic                 sweep_done_q;
  logic [N_IN:0]        ones_q;
  logic                 sweeping;
  logic [N_IN:0]        acc_next;

  assign sweeping = (state == S_SWEEP);
  assign acc_next = acc + {{N_IN{1'b0}}, tbl[idx]};

  // Eval and config paths. The eval read uses the pre-edge table, so a
  // same-cycle write to the same address returns the old bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl         <= DEF_TABLE;
      out_x_q     <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_x_q <= tbl[bus.in_vec];
      end
      // Writes are refused while sweeping so the count reflects one snapshot.
      cfg_err_q <= bus.cfg_we && sweeping;
      if (bus.cfg_we && !sweeping) begin
        tbl[bus.cfg_addr] <= bus.cfg_data;
      end
    end
  end

  // Sweep FSM. busy and sweep_done are registered at the state transitions
  // so they line up exactly with the SWEEP and DONE cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      acc          <= '0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      ones_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          sweep_done_q <= 1'b0;
          if (bus.sweep_start) begin
            state  <= S_SWEEP;
            idx    <= '0;
            acc    <= '0;
            ones_q <= '0;
            busy_q <= 1'b1;
          end
        end
        S_SWEEP: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          // Terminal detection on the last index; the wrap to zero is harmless.
          if (idx == {N_IN{1'b1}}) begin
            state        <= S_DONE;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b1;
            ones_q       <= acc_next;
          end
        end
        S_DONE: begin
          state        <= S_IDLE;
          sweep_done_q <= 1'b0;
        end
        default: begin
          state        <= S_IDLE;
          busy_q       <= 1'b0;
          sweep_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_x      = out_x_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = sweep_done_q;
  assign bus.ones_count = ones_q;

endmodule

// File: tb/tb_bf_lut_eval.sv
// tb/tb_bf_lut_eval.sv - scoreboard bench for bf_lut_eval with random traffic
module tb_bf_lut_eval;

  localparam int N_IN = 3;
  localparam int DEPTH = 1 << N_IN;
  localparam logic [DEPTH-1:0] DEF = 8'h57;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bf_lut_eval_if #(.N_IN(N_IN)) bus ();

  bf_lut_eval #(.N_IN(N_IN), .DEF_TABLE(DEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: the table as a plain bit array plus a countdown of
  // remaining sweep cycles.
  logic [DEPTH-1:0] m_tbl;
  int               sweep_left;
  bit               in_done;
  int               m_ones;
  bit               exp_err;
  logic             eval_q[$];
  int               sweep_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        if (eval_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("out_x", int'(bus.out_x), int'(eval_q.pop_front()));
      end
      if (bus.sweep_done) begin
        if (sweep_q.size() == 0) chk("unexpected_sweep_done", 1, 0);
        else chk("ones_count_at_done", int'(bus.ones_count), sweep_q.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_vec      = '0;
    bus.cfg_we      = 1'b0;
    bus.cfg_addr    = '0;
    bus.cfg_data    = 1'b0;
    bus.sweep_start = 1'b0;
  endtask

  task automatic model_reset();
    m_tbl      = DEF;
    sweep_left = 0;
    in_done    = 1'b0;
    m_ones     = 0;
    exp_err    = 1'b0;
    eval_q.delete();
    sweep_q.delete();
  endtask

  // One clock edge: advance the model with the current inputs, then check
  // the status outputs after the edge.
  task automatic step();
    bit busy_now, done_now;
    busy_now = (sweep_left > 0);
    done_now = in_done;
    if (bus.in_valid) eval_q.push_back(m_tbl[bus.in_vec]);
    exp_err = bus.cfg_we && busy_now;
    if (bus.cfg_we && !busy_now) m_tbl[bus.cfg_addr] = bus.cfg_data;
    in_done = 1'b0;
    if (busy_now) begin
      sweep_left--;
      if (sweep_left == 0) begin
        in_done = 1'b1;
        m_ones  = $countones(m_tbl);
        sweep_q.push_back(m_ones);
      end
    end else if (!done_now && bus.sweep_start) begin
      sweep_left = DEPTH;
      m_ones     = 0;
    end
    @(posedge clk);
    #1;
    chk("busy", int'(bus.busy), int'(sweep_left > 0));
    chk("sweep_done", int'(bus.sweep_done), int'(in_done));
    chk("cfg_err", int'(bus.cfg_err), int'(exp_err));
    chk("ones_count", int'(bus.ones_count), m_ones);
  endtask

  task automatic eval(input logic [N_IN-1:0] v);
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    step();
    idle_inputs();
  endtask

  task automatic cfg_write(input logic [N_IN-1:0] a, input logic d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    step();
    idle_inputs();
  endtask

  task automatic start_sweep();
    bus.sweep_start = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ones_count", int'(bus.ones_count), 0);
    chk("rst_sweep_done", int'(bus.sweep_done), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_x", int'(bus.out_x), 0);
    chk("rst_cfg_err", int'(bus.cfg_err), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    do_reset();

    // Default table evaluations.
    eval(3'b000);
    eval(3'b011);
    eval(3'b110);
    step();

    // Default sweep, then one extra true minterm.
    start_sweep();
    repeat (DEPTH + 2) step();
    cfg_write(3'd3, 1'b1);
    start_sweep();
    repeat (DEPTH + 2) step();
    chk("ones_after_write", int'(bus.ones_count), 6);

    // Write rejected mid-sweep.
    cfg_write(3'd3, 1'b0);
    start_sweep();
    step();
    cfg_write(3'd7, 1'b1);
    repeat (DEPTH + 2) step();
    chk("ones_after_rejected_write", int'(bus.ones_count), 5);
    eval(3'b111);

    // Read-before-write on the same address.
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd2; bus.cfg_data = 1'b0;
    bus.in_valid = 1'b1; bus.in_vec = 3'd2;
    step();
    idle_inputs();
    eval(3'd2);
    step();

    // Reset in the fourth sweep cycle.
    start_sweep();
    repeat (3) step();
    do_reset();
    repeat (DEPTH + 3) step();
    eval(3'd2);
    eval(3'd3);
    eval(3'd7);
    step();

    // All-ones table, with a start request ignored while busy.
    for (int i = 0; i < DEPTH; i++) cfg_write(N_IN'(i), 1'b1);
    start_sweep();
    repeat (3) step();
    bus.sweep_start = 1'b1;
    step();
    idle_inputs();
    repeat (DEPTH + 2) step();
    chk("ones_all_true", int'(bus.ones_count), DEPTH);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid    = 1'($urandom_range(0, 1));
      bus.in_vec      = N_IN'($urandom_range(0, DEPTH - 1));
      bus.cfg_we      = ($urandom_range(0, 5) == 0);
      bus.cfg_addr    = N_IN'($urandom_range(0, DEPTH - 1));
      bus.cfg_data    = 1'($urandom_range(0, 1));
      bus.sweep_start = ($urandom_range(0, 12) == 0);
      step();
    end
    idle_inputs();
    repeat (DEPTH + 3) step();

    chk("eval_queue_drained", eval_q.size(), 0);
    chk("sweep_queue_drained", sweep_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bf_lut_eval.md
Name: bf_lut_eval

Overview:
- Programmable N-input boolean-function unit. An 2^N-bit truth table, writable at run time, defines the function.
- Evaluates input vectors with a registered 1-cycle output.
- A sweep mode enumerates all minterms and reports how many evaluate true.
- Sits in the lab datapath as the configurable replacement for fixed combinational boolean-function blocks.

Parameters:
- N_IN, 3, number of function inputs; table depth is 2^N_IN (valid range 1..8).
- DEF_TABLE, 8'h57, truth-table reset value, width 2^N_IN. Bit i is the output for in_vec == i. The default encodes (~a&~b)|~c with index {a,b,c}.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_vec  input  N_IN  input vector to evaluate (index into table)
- in_valid  input  1  evaluate in_vec this cycle
- out_x  output  1  registered function result
- out_valid  output  1  out_x valid, one cycle after in_valid
- cfg_we  input  1  truth-table bit write strobe
- cfg_addr  input  N_IN  table bit to write
- cfg_data  input  1  value written
- cfg_err  output  1  1-cycle pulse: write rejected (sweep busy)
- sweep_start  input  1  start minterm enumeration
- busy  output  1  sweep in progress
- sweep_done  output  1  1-cycle pulse: ones_count final
- ones_count  output  N_IN+1  number of true minterms from last sweep

Behaviour:
- Clocking and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values:
  - table = DEF_TABLE.
  - out_x=0, out_valid=0, cfg_err=0, busy=0, sweep_done=0, ones_count=0.
  - FSM=IDLE, sweep index=0.
- Reset mid-sweep: aborts the sweep immediately, restores all of the above, and discards any partial count.
- Eval path:
  - Independent of the FSM and active in every state.
  - On in_valid at edge k: out_x = table[in_vec] as held before edge k, and out_valid=1 during cycle k+1.
  - Without in_valid: out_valid=0 and out_x holds its last value.
- Read-before-write: cfg_we and in_valid in the same cycle to the same address give out_x = the old bit; the new bit takes effect from the next evaluation.
- Config path:
  - In IDLE or DONE, cfg_we writes table[cfg_addr] = cfg_data at the edge.
  - In SWEEP, the write is dropped and cfg_err pulses in the following cycle. This keeps the count consistent with a single table snapshot.
- FSM states IDLE, SWEEP, DONE:
  - IDLE, sweep_start=1: go to SWEEP. Index=0, accumulator=0, ones_count cleared to 0, busy=1 next cycle.
  - SWEEP: each cycle, accumulator += table[index] and index++. After index 2^N_IN-1 is added, go to DONE. SWEEP lasts exactly 2^N_IN cycles.
  - DONE: lasts one cycle. ones_count = final accumulator, sweep_done=1, busy=0. Then go to IDLE unconditionally.
  - sweep_start in SWEEP is ignored. sweep_start in DONE is ignored; it must be re-issued in IDLE.
- Sweep latency: sweep_start sampled at edge 0 gives busy high in cycles 1..2^N_IN and sweep_done in cycle 2^N_IN+1.
- Width rules:
  - Accumulator and ones_count are N_IN+1 bits so the all-ones table (2^N_IN) does not overflow.
  - Index is N_IN+1 bits or uses terminal detection, so it never wraps early.
- ones_count holds its value until the next accepted sweep_start.

Test Plan:
- Reset, N_IN=3: in_vec=3'b000, in_valid=1 -> next cycle out_valid=1, out_x=1. in_vec=3'b011 -> out_x=0. in_vec=3'b110 -> out_x=1.
- Sweep with default table 8'h57 -> busy high 8 cycles, sweep_done in cycle 9, ones_count=5. cfg_we, cfg_addr=3, cfg_data=1, then sweep -> ones_count=6.
- cfg_we during SWEEP (addr 7, data 1) -> cfg_err pulse next cycle, ones_count=5, later eval of 3'b111 -> out_x=0.
- Same-cycle cfg_we addr 2 data 0 and in_valid in_vec=2 -> out_x=1. Repeat eval -> out_x=0.
- rst_n low at SWEEP cycle 4 -> busy=0, ones_count=0, table=8'h57 immediately. No sweep_done is produced afterwards.
- Write all 8 bits to 1, sweep -> ones_count=8 (4'b1000, no overflow). sweep_start during busy -> no restart, done still in cycle 9.
